// File: rtl/pattern_count_engine.sv
// Streams NBYTES bytes from memory and counts masked pattern matches:
// in-byte windows, bytes with any in-byte match, and whole-string windows.
module pattern_count_engine #(
  parameter int unsigned DW     = 8,
  parameter int unsigned PW     = 5,
  parameter int unsigned NBYTES = 32,
  parameter int unsigned AW     = 8,
  parameter int unsigned CW     = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [PW-1:0] pat,
  input  logic [PW-1:0] pat_mask,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] ctb,
  output logic [CW-1:0] cto,
  output logic [CW-1:0] cts
);

  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned NW = $clog2(DW + 1) + 1;
  localparam int unsigned SW = ((CW > NW) ? CW : NW) + 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  localparam logic [SW-1:0] CMAX = {{(SW-CW){1'b0}}, {CW{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic [AW-1:0]   r_addr;
  logic [PW-1:0]   r_pat, r_mask;
  logic [PW-2:0]   r_hist;
  logic            r_valid, r_first;
  logic [CW-1:0]   r_ctb, r_cto, r_cts;
  logic            w_accept;
  logic [DW+PW-2:0] w_ext;
  logic [NW-1:0]   w_in_cnt, w_x_cnt;
  logic [CW-1:0]   w_ctb_nxt, w_cto_nxt, w_cts_nxt;

  function automatic logic f_match(input logic [PW-1:0] w, p, m);
    return ((w ^ p) & m) == '0;
  endfunction

  function automatic logic [CW-1:0] f_sat(input logic [CW-1:0] a, input logic [NW-1:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return (s > CMAX) ? '1 : s[CW-1:0];
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_accept    = 1'b1;
        w_state_nxt = S_READ;
      end
      S_READ: begin
        mem_rd   = 1'b1;
        mem_addr = r_addr;
        busy     = 1'b1;
        if (r_idx == LAST) w_state_nxt = S_DRAIN;
      end
      // Stay until the last returned byte has been folded into the counts.
      S_DRAIN: begin
        busy = 1'b1;
        if (!r_valid) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Windows with lowest bit at k < DW-PW+1 lie inside the byte; the rest cross.
  always_comb begin
    w_ext    = {r_hist, mem_rdata};
    w_in_cnt = '0;
    w_x_cnt  = '0;
    for (int unsigned k = 0; k <= DW - PW; k++)
      if (f_match(w_ext[k +: PW], r_pat, r_mask)) w_in_cnt = w_in_cnt + NW'(1);
    for (int unsigned k = DW - PW + 1; k < DW; k++)
      if (f_match(w_ext[k +: PW], r_pat, r_mask)) w_x_cnt = w_x_cnt + NW'(1);
    w_ctb_nxt = f_sat(r_ctb, w_in_cnt);
    w_cto_nxt = f_sat(r_cto, NW'(w_in_cnt != '0));
    w_cts_nxt = f_sat(r_cts, r_first ? w_in_cnt : w_in_cnt + w_x_cnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_addr  <= '0;
      r_pat   <= '0;
      r_mask  <= '0;
      r_hist  <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_ctb   <= '0;
      r_cto   <= '0;
      r_cts   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (r_state == S_READ);
      if (w_accept) begin
        r_pat   <= pat;
        r_mask  <= pat_mask;
        r_addr  <= base_addr;
        r_idx   <= '0;
        r_hist  <= '0;
        r_first <= 1'b1;
        r_ctb   <= '0;
        r_cto   <= '0;
        r_cts   <= '0;
      end else begin
        if (r_state == S_READ) begin
          r_addr <= r_addr + AW'(1);
          r_idx  <= r_idx + IW'(1);
        end
        if (r_valid) begin
          r_ctb   <= w_ctb_nxt;
          r_cto   <= w_cto_nxt;
          r_cts   <= w_cts_nxt;
          r_hist  <= mem_rdata[PW-2:0];
          r_first <= 1'b0;
        end
      end
    end
  end

  assign ctb = r_ctb;
  assign cto = r_cto;
  assign cts = r_cts;

endmodule

// File: tb/tb_pattern_count_engine.sv
// Directed bench for pattern_count_engine: default build plus two small
// builds (normal width and saturating width) sharing clock and reset.
module tb_pattern_count_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start_s;
  logic [7:0] base_addr;
  logic [4:0] pat, pat_mask;
  logic       mem_rd, busy, done;
  logic [7:0] mem_addr, rdata_m;
  logic [8:0] ctb, cto, cts;

  logic [2:0] pat_s, mask_s;
  logic       rd_s, busy_s, done_s, rd_t, busy_t, done_t;
  logic [7:0] addr_s, addr_t, rdata_s, rdata_t;
  logic [5:0] ctb_s, cto_s, cts_s;
  logic [2:0] ctb_t, cto_t, cts_t;

  logic [7:0] mem [256];

  always_ff @(posedge clk) begin
    rdata_m <= mem[mem_addr];
    rdata_s <= 8'hFF;
    rdata_t <= 8'hFF;
  end

  pattern_count_engine dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .pat(pat), .pat_mask(pat_mask), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(rdata_m), .busy(busy), .done(done), .ctb(ctb), .cto(cto), .cts(cts));

  pattern_count_engine #(.DW(8), .PW(3), .NBYTES(4), .AW(8), .CW(6)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .base_addr(8'h00),
    .pat(pat_s), .pat_mask(mask_s), .mem_rd(rd_s), .mem_addr(addr_s),
    .mem_rdata(rdata_s), .busy(busy_s), .done(done_s), .ctb(ctb_s), .cto(cto_s), .cts(cts_s));

  pattern_count_engine #(.DW(8), .PW(3), .NBYTES(4), .AW(8), .CW(3)) dut_t (
    .clk(clk), .reset(reset), .start(start_s), .base_addr(8'h00),
    .pat(pat_s), .pat_mask(mask_s), .mem_rd(rd_t), .mem_addr(addr_t),
    .mem_rdata(rdata_t), .busy(busy_t), .done(done_t), .ctb(ctb_t), .cto(cto_t), .cts(cts_t));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  // Issues one start, then samples 1 time unit after every edge until done.
  task automatic run_main(input logic [7:0] base, input logic [4:0] p, input logic [4:0] m,
                          input int restart_at, input int reset_at,
                          output int done_at, output int rd_cnt, output int addr_err);
    done_at = -1; rd_cnt = 0; addr_err = 0;
    @(negedge clk);
    base_addr = base; pat = p; pat_mask = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (n == reset_at) begin
        reset = 1'b1; #1;
        check_eq("rst_mid_rd",   mem_rd,   0);
        check_eq("rst_mid_addr", mem_addr, 0);
        check_eq("rst_mid_busy", busy,     0);
        check_eq("rst_mid_done", done,     0);
        check_eq("rst_mid_cnts", {ctb, cto, cts}, 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (n == restart_at) begin start = 1'b1; pat = ~p; base_addr = base + 8'h40; end
      if (n == restart_at + 1) start = 1'b0;
      if (mem_rd) begin
        if (mem_addr !== base + 8'(rd_cnt)) addr_err++;
        rd_cnt++;
      end
      if (done) begin done_at = n; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_run(input string tag, input int done_at, input int rd_cnt, input int addr_err,
                            input int e_ctb, input int e_cto, input int e_cts);
    check_eq({tag, "_done_lat"}, done_at, 34);
    check_eq({tag, "_rd_cycles"}, rd_cnt, 32);
    check_eq({tag, "_addr_err"}, addr_err, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_ctb"}, ctb, e_ctb);
    check_eq({tag, "_cto"}, cto, e_cto);
    check_eq({tag, "_cts"}, cts, e_cts);
  endtask

  int d, r, a, ds;

  initial begin
    reset = 1'b1; start = 1'b0; start_s = 1'b0;
    base_addr = '0; pat = '0; pat_mask = '0; pat_s = '0; mask_s = '0;
    fill(8'h00);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd",   mem_rd,   0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_busy", busy,     0);
    check_eq("rst_done", done,     0);
    check_eq("rst_cnts", {ctb, cto, cts}, 0);
    @(negedge clk);
    reset = 1'b0;

    fill(8'h55);
    run_main(8'h00, 5'b10101, 5'b11111, -1, -1, d, r, a);
    expect_run("alt55", d, r, a, 64, 32, 126);
    @(posedge clk); #1;
    check_eq("hold_done", done, 1);
    check_eq("hold_ctb", ctb, 64);

    fill(8'h00);
    run_main(8'h00, 5'b00000, 5'b11111, -1, -1, d, r, a);
    expect_run("zeros", d, r, a, 128, 32, 252);

    mem[0] = 8'h07; mem[1] = 8'hC0;
    run_main(8'h00, 5'b11111, 5'b11111, -1, -1, d, r, a);
    expect_run("cross", d, r, a, 0, 0, 1);

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    run_main(8'h00, 5'b10110, 5'b00000, -1, -1, d, r, a);
    expect_run("nomask", d, r, a, 128, 32, 252);

    fill(8'h00);
    run_main(8'hF0, 5'b00000, 5'b11111, -1, -1, d, r, a);
    expect_run("wrap", d, r, a, 128, 32, 252);

    fill(8'h55);
    run_main(8'h00, 5'b10101, 5'b11111, 5, -1, d, r, a);
    expect_run("restart_ign", d, r, a, 64, 32, 126);

    run_main(8'h00, 5'b10101, 5'b11111, -1, 10, d, r, a);
    @(posedge clk); #1;
    check_eq("post_rst_idle", {busy, done, mem_rd}, 0);

    run_main(8'h00, 5'b10101, 5'b11111, -1, -1, d, r, a);
    expect_run("after_rst", d, r, a, 64, 32, 126);

    @(negedge clk);
    pat_s = 3'b111; mask_s = 3'b111; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    ds = -1;
    for (int n = 0; n < 40; n++) begin
      if (done_s && done_t) begin ds = n; break; end
      @(posedge clk); #1;
    end
    check_eq("small_done_lat", ds, 6);
    check_eq("small_ctb", ctb_s, 24);
    check_eq("small_cto", cto_s, 4);
    check_eq("small_cts", cts_s, 30);
    check_eq("sat_ctb", ctb_t, 7);
    check_eq("sat_cto", cto_t, 4);
    check_eq("sat_cts", cts_t, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pattern_count_engine.md
Name: pattern_count_engine

Overview:
Hardware accelerator for the program-3 pattern-count task, generalised in byte width, pattern width, string length and match mode (per-bit don't-care mask). On a start pulse it streams NBYTES bytes from data memory through a one-cycle-latency read port. It produces three counts:
- in-byte window matches,
- bytes containing at least one in-byte match,
- matches anywhere in the concatenated bit string, including windows that cross byte boundaries.

It sits beside the core as a memory-reading peripheral and raises a held done level on completion.

Parameters:
DW, 8, data/byte width in bits
PW, 5, pattern width in bits; legal range 2 <= PW <= DW
NBYTES, 32, bytes in the search string; must be >= 1
AW, 8, memory address width
CW, 9, count width; must be >= clog2(NBYTES*DW+1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle start request; sampled only in IDLE or DONE
base_addr  in  AW  address of byte 0; sampled on accepted start
pat  in  PW  pattern; sampled on accepted start
pat_mask  in  PW  per-bit compare enable (1 = compare, 0 = don't care); sampled on accepted start
mem_rd  out  1  read strobe
mem_addr  out  AW  read address
mem_rdata  in  DW  read data, valid the cycle after mem_rd
busy  out  1  high from accepted start until done rises
done  out  1  level; high in DONE until the next accepted start or reset
ctb  out  CW  in-byte window match count
cto  out  CW  count of bytes with >= 1 in-byte match
cts  out  CW  full-string match count, byte crossings included

Behaviour:
- Reset (async): state IDLE; mem_rd=0, mem_addr=0, busy=0, done=0, ctb/cto/cts=0, history cleared.
- Bit order: byte 0 comes first. Within a byte, bit DW-1 comes first. The string is byte0[DW-1:0], byte1[DW-1:0], ...
- Match rule: window w matches when ((w ^ pat_latched) & mask_latched) == 0.
- FSM IDLE/DONE -> READ on start:
  - latch pat, mask and base_addr;
  - clear all counts and history;
  - done<=0, busy<=1.
- READ: one read per cycle, mem_rd=1, mem_addr=base+i for i=0..NBYTES-1. Address arithmetic wraps modulo 2^AW. After issuing i=NBYTES-1, go to DRAIN.
- DRAIN: mem_rd=0; process the final byte; then go to DONE, with done<=1 and busy<=0.
- Byte processing happens in the cycle mem_rdata is valid; one byte per cycle, fully pipelined.
  - ctb += number of k in 0..DW-PW where byte[k+PW-1:k] matches.
  - cto += 1 if that number is > 0.
  - cts: for byte 0, the same DW-PW+1 windows. For later bytes, the DW windows of {history[PW-2:0], byte} whose lowest bit lies in this byte.
  - history <= low PW-1 bits of the byte.
- Total cts windows = NBYTES*DW-PW+1.
- Latency: start accepted at edge T.
  - mem_rd high in cycles T+1..T+NBYTES.
  - Last byte processed at edge T+NBYTES+1.
  - done, and final counts, visible from edge T+NBYTES+2.
- Counts update every cycle during processing. They are final only when done=1 and are held until the next accepted start.
- Counts saturate at 2^CW-1 and never wrap.
- start while busy: ignored, no effect on state or counts.
- start in DONE: restarts; done drops the next cycle.
- start held high: treated as a new request each time the FSM reaches DONE.
- Reset mid-operation: immediate return to the reset values above; any pending read data is discarded.
- pat_mask=0: every window matches.

Test Plan:
- Defaults; all 32 bytes 0x55; pat=10101; mask=11111; start -> ctb=64, cto=32, cts=126; done rises exactly 34 cycles after start edge; mem_rd high for exactly 32 cycles on addresses base..base+31.
- Defaults; all bytes 0x00; pat=00000; mask=11111 -> ctb=128, cto=32, cts=252.
- Defaults; byte0=0x07, byte1=0xC0, rest 0x00; pat=11111; mask=11111 -> ctb=0, cto=0, cts=1 (crossing-only match).
- Defaults; random data; mask=00000 -> ctb=128, cto=32, cts=252.
- Defaults; base_addr=0xF0 -> reads wrap 0xF0..0xFF then 0x00..0x0F.
- Defaults; second start pulse mid-run -> ignored.
- Defaults; reset asserted at cycle 10 of a run -> all outputs 0 the same cycle.
- Defaults; fresh start after that reset -> correct counts.
- DW=8, PW=3, NBYTES=4, CW=6; bytes 0xFF x4; pat=111; mask=111 -> ctb=24, cto=4, cts=30.
- DW=8, PW=3, NBYTES=4, CW=3 (sub-minimum width, deliberately set); same data -> ctb=7, cts=7 (saturation); cto=4.
